// File: rtl/core_mem_pkg.sv
// ---------------------------------------------------------------------------
// core_mem_pkg
//
// Shared types for the core's memory arbiter: the arbiter FSM state, the
// owner of the single outstanding bus transaction, the request bundle that
// is held on the bus, and the default widths used by the datapath.
// ---------------------------------------------------------------------------
package core_mem_pkg;

    // Default bus geometry of the core.
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    // Starvation counter width; large enough for the widest bound (15).
    localparam int STARVE_W = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no transaction held
        ST_REQ  = 2'd1,   // request presented, waiting for bus acceptance
        ST_RSP  = 2'd2    // request accepted, waiting for bus response
    } mem_arb_state_t;

    // Which pipeline port owns the outstanding transaction.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } mem_owner_t;

    // Request bundle as presented on the unified memory bus.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//
// Merges the instruction-fetch port and the load/store port onto the core's
// single memory bus. One transaction is outstanding at a time. Data accesses
// win by default; after STARVE_MAX consecutive data grants taken while a
// fetch was waiting, the fetch is granted. A redirect (if_flush) while a
// fetch is in flight lets the bus transaction finish but swallows its
// response.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req_*            fetch request (valid/ready handshake, address)
//   if_flush            redirect: discard the outstanding fetch response
//   if_rsp_valid/data   fetch response
//   ls_req_*            load/store request (valid/ready, addr, we, wdata, wstrb)
//   ls_rsp_valid/rdata  load data or store acknowledge
//   mem_req_*           registered bus request (valid/ready handshake)
//   mem_rsp_valid/rdata bus response
// ---------------------------------------------------------------------------
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_we,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    // Saturating increment of the starvation counter at STARVE_LIM.
    function automatic logic [STARVE_W-1:0] starve_sat_inc(input logic [STARVE_W-1:0] v);
        if (v >= STARVE_LIM) begin
            return STARVE_LIM;
        end
        return v + 1'b1;
    endfunction

    mem_arb_state_t      state_q;
    mem_arb_state_t      state_d;
    mem_owner_t          owner_q;
    logic                drop_q;
    logic [STARVE_W-1:0] starve_q;

    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic                grant_if;
    logic                grant_ls;
    logic                rsp_fire;

    // -----------------------------------------------------------------------
    // Next-state, grant and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_if      = 1'b0;
        grant_ls      = 1'b0;
        rsp_fire      = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_rsp_valid  = 1'b0;
        if_rsp_data   = '0;
        ls_rsp_valid  = 1'b0;
        ls_rsp_rdata  = '0;
        mem_req_valid = 1'b0;

        // Grants are only decided in IDLE and never while reset is held, so
        // neither requester sees a ready during reset.
        if (!rst && state_q == ST_IDLE) begin
            if (if_req_valid && (!ls_req_valid || starve_q == STARVE_LIM)) begin
                grant_if = 1'b1;
            end else if (ls_req_valid) begin
                grant_ls = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_ls) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                // A bus response is only meaningful here; outside RSP it is ignored.
                rsp_fire = mem_rsp_valid && !rst;
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                end
                if (owner_q == OWN_IF) begin
                    if_rsp_data = mem_rsp_rdata;
                end else begin
                    ls_rsp_rdata = mem_rsp_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if_req_ready = grant_if;
        ls_req_ready = grant_ls;

        // A flush arriving in the very cycle the fetch data returns must also
        // swallow it, hence the direct if_flush term next to the drop flag.
        if_rsp_valid = rsp_fire && (owner_q == OWN_IF) && !drop_q && !if_flush;
        ls_rsp_valid = rsp_fire && (owner_q == OWN_LS);
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

    // -----------------------------------------------------------------------
    // State, owner, drop flag, starvation counter and held request
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            drop_q   <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q <= state_d;

            if (grant_if) begin
                // Fetches are always reads with no byte lanes enabled.
                owner_q  <= OWN_IF;
                addr_q   <= if_req_addr;
                we_q     <= 1'b0;
                wdata_q  <= '0;
                wstrb_q  <= '0;
                starve_q <= '0;
            end else if (grant_ls) begin
                owner_q  <= OWN_LS;
                addr_q   <= ls_req_addr;
                we_q     <= ls_req_we;
                wdata_q  <= ls_req_wdata;
                wstrb_q  <= ls_req_wstrb;
                // Only data grants taken over a waiting fetch count toward
                // starvation; a data grant with no fetch pending restarts it.
                starve_q <= if_req_valid ? starve_sat_inc(starve_q) : '0;
            end

            // The drop flag lives for exactly one transaction.
            if (state_d == ST_IDLE) begin
                drop_q <= 1'b0;
            end else if (if_flush && owner_q == OWN_IF && state_q != ST_IDLE) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Arbitrates the pipeline's instruction-fetch port (IF stage) and data port (load/store stage) onto the core's single unified memory bus. Only one transaction is outstanding at a time. Data accesses have priority, with a starvation bound that guarantees forward progress for instruction fetch. The block also drops in-flight fetch responses on a branch/jump redirect. It sits between `if_stage`, `load_store_stage` and the external memory interface of `core_datapath`.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high. These are the only clock and reset.

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `STARVE_MAX`, 4: maximum consecutive data grants while a fetch waits; range 1..15.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `if_req_valid`  in  1  fetch request
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_req_addr`  in  ADDR_W  fetch address
- `if_flush`  in  1  redirect; discard the outstanding fetch response
- `if_rsp_valid`  out  1  fetch data valid
- `if_rsp_data`  out  DATA_W  instruction word
- `ls_req_valid`  in  1  load/store request
- `ls_req_ready`  out  1  load/store request accepted this cycle
- `ls_req_addr`  in  ADDR_W  data address
- `ls_req_we`  in  1  1 = store
- `ls_req_wdata`  in  DATA_W  store data
- `ls_req_wstrb`  in  DATA_W/8  byte enables
- `ls_rsp_valid`  out  1  load data, or store acknowledge
- `ls_rsp_rdata`  out  DATA_W  load data
- `mem_req_valid`  out  1  bus request
- `mem_req_ready`  in  1  bus accepts request
- `mem_req_addr`, `mem_req_we`, `mem_req_wdata`, `mem_req_wstrb`  out  as above  registered request
- `mem_rsp_valid`  in  1  bus response
- `mem_rsp_rdata`  in  DATA_W  bus read data

## Operation
- States:
  - IDLE: no transaction held.
  - REQ: `mem_req_valid`=1; waiting for `mem_req_ready`.
  - RSP: waiting for `mem_rsp_valid`.
- State transitions:
  - IDLE→REQ when any request is granted.
  - REQ→RSP on `mem_req_ready`.
  - RSP→IDLE on `mem_rsp_valid`.
- Grant, evaluated only in IDLE and combinational:
  - Data wins by default.
  - Fetch wins if `ls_req_valid`=0, or if `starve_cnt`==`STARVE_MAX` and `if_req_valid`=1.
  - The granted port's `*_req_ready`=1 that cycle. Readies are 0 in all other states and during reset.
- On grant, the request fields and the owner (IF/LS) are registered. Fetches are driven with `we`=0, `wstrb`=0, `wdata`=0.
- `starve_cnt`:
  - +1 on each data grant while `if_req_valid`=1, saturating at `STARVE_MAX`.
  - Cleared on a fetch grant, or on a data grant while `if_req_valid`=0.
- Responses are routed combinationally in RSP: `if_rsp_valid` = `mem_rsp_valid` & owner==IF & !`drop`; `ls_rsp_valid` = `mem_rsp_valid` & owner==LS. Data passes through unchanged. Stores also pulse `ls_rsp_valid`.
- Flush handling:
  - `if_flush` in REQ or RSP with owner==IF sets `drop`.
  - The bus transaction still completes, and its response is swallowed. `drop` clears on returning to IDLE.
  - `if_flush` in IDLE, or with owner==LS, has no effect. A fetch request presented in the same cycle as a flush is treated as the redirected fetch and is eligible for grant.
- `mem_rsp_valid` outside RSP is ignored.

## Timing
- Reset values: state IDLE, owner IF, `drop`=0, `starve_cnt`=0, all outputs 0.
- Minimum latency, zero-wait bus:
  - Cycle 0: request accepted.
  - Cycle 1: `mem_req_valid`=1 and bus handshake.
  - Cycle 2: response, returned to the requester in the same cycle.
  - Cycle 3: IDLE, next grant.
- Peak throughput is one transaction per 3 cycles.
- The `mem_req_*` fields are stable from REQ entry until the handshake.
- Reset asserted mid-transaction abandons it immediately: no `*_rsp_valid` is emitted. The memory side shares `rst`.
- Simultaneous `if_flush` and `mem_rsp_valid` in RSP with owner==IF: the response is dropped.

## Structure
- Package `core_mem_pkg` holds:
  - `mem_arb_state_t` (IDLE/REQ/RSP)
  - `mem_owner_t` (IF/LS)
  - a `mem_req_t` struct (addr, we, wdata, wstrb)
  - width localparams
- No sub-module: a single FSM with request register and counter.

## Test plan
- Fetch only, addr 0x100, zero-wait bus, rdata 0x00000013: `if_req_ready` in cycle 0; `mem_req_valid` in cycle 1; `if_rsp_valid` with 0x00000013 in cycle 2; next grant in cycle 3.
- Simultaneous fetch 0x200 and store 0x1000/0xDEADBEEF/wstrb 0xF: store is granted first; fetch is granted after the store's `ls_rsp_valid`.
- Continuous loads with fetch held valid, `STARVE_MAX`=4: exactly 4 data grants, then a fetch grant, then data again.
- Fetch granted, `if_flush` in RSP, bus response 0xCAFEBABE: `if_rsp_valid` stays 0; the next fetch completes normally.
- `mem_req_ready` held low 5 cycles: `mem_req_*` stable; both `*_req_ready`=0; `rst` pulsed in RSP returns IDLE with no response.
